// File: rtl/stopwatch_pkg.sv
// Widths and defaults shared by the stopwatch and its input conditioner.
package stopwatch_pkg;

   localparam int DB_CYCLES_DEFAULT = 500000;
   localparam int DB_CNT_W          = 20;
   localparam int MISS_Q_W          = 2;
   localparam int MISS_CNT_W        = 8;
   localparam int LOCKOUT_CNT_W     = 22;

   // Score counter sticks at all-ones instead of wrapping.
   function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stable-count debounce, registered rising-edge pulse.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

   logic                sync_1;
   logic                sync_x;
   logic                level_d;
   logic [DB_CNT_W-1:0] db_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1  <= 1'b0;
         sync_x  <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         db_cnt  <= '0;
      end else begin
         sync_1  <= raw;
         sync_x  <= sync_1;
         level_d <= level;
         press   <= level & ~level_d;
         if (sync_x == level) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            level  <= sync_x;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Stopwatch front end: debounced start toggle, held miss-request queue and score count.
// Build option MISS_LOCKOUT_EN adds a re-arm lockout after each accepted miss press.
module input_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
   parameter int MISS_Q_MAX     = 3
`ifdef MISS_LOCKOUT_EN
  ,parameter int LOCKOUT_CYCLES = 2500000
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  btn_start,
   input  logic                  btn_miss,
   input  logic                  tick_ack,
   input  logic                  fail,
   output logic                  start,
   output logic                  miss,
   output logic [MISS_CNT_W-1:0] miss_count,
   output logic                  miss_dropped
);

   localparam logic [MISS_Q_W-1:0] Q_MAX = MISS_Q_W'(MISS_Q_MAX);

   logic                press_start;
   logic                press_miss;
   logic                accept;
   logic                lock_ok;
   logic                cnt_inc;
   logic                drop_next;
   logic [MISS_Q_W-1:0] miss_q;
   logic [MISS_Q_W-1:0] miss_q_next;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clock (clock),
      .reset (reset),
      .raw   (btn_start),
      .level (),
      .press (press_start)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_miss (
      .clock (clock),
      .reset (reset),
      .raw   (btn_miss),
      .level (),
      .press (press_miss)
   );

`ifdef MISS_LOCKOUT_EN
   logic [LOCKOUT_CNT_W-1:0] lock_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_cnt <= '0;
      end else if (fail) begin
         lock_cnt <= '0;
      end else if (accept) begin
         lock_cnt <= LOCKOUT_CNT_W'(LOCKOUT_CYCLES);
      end else if (lock_cnt != '0) begin
         lock_cnt <= lock_cnt - 1'b1;
      end
   end

   assign lock_ok = (lock_cnt == '0);
`else
   assign lock_ok = 1'b1;
`endif

   // Only a running, non-failed stopwatch can take a miss.
   assign accept = press_miss & start & ~fail & lock_ok;
   assign miss   = (miss_q != '0);

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      miss_q_next = miss_q;
      cnt_inc     = 1'b0;
      drop_next   = 1'b0;
      if (fail) begin
         miss_q_next = '0;
      end else if (accept && tick_ack) begin
         cnt_inc = 1'b1;
         if (miss_q == '0) miss_q_next = MISS_Q_W'(1);
      end else if (accept) begin
         if (miss_q != Q_MAX) begin
            miss_q_next = miss_q + 1'b1;
            cnt_inc     = 1'b1;
         end else begin
            drop_next = 1'b1;
         end
      end else if (tick_ack && miss_q != '0) begin
         miss_q_next = miss_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         start        <= 1'b0;
         miss_q       <= '0;
         miss_count   <= '0;
         miss_dropped <= 1'b0;
      end else begin
         if (fail)             start <= 1'b0;
         else if (press_start) start <= ~start;
         miss_q       <= miss_q_next;
         miss_dropped <= drop_next;
         if (cnt_inc) miss_count <= sat_inc(miss_count);
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DB_CYCLES=4 (LOCKOUT_CYCLES=8 when MISS_LOCKOUT_EN).
module tb_input_conditioner;

   localparam int DB = 4;
`ifdef MISS_LOCKOUT_EN
   localparam int LOCK = 8;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       btn_start;
   logic       btn_miss;
   logic       tick_ack;
   logic       fail;
   logic       start;
   logic       miss;
   logic [7:0] miss_count;
   logic       miss_dropped;

   int total = 0;
   int bad   = 0;

   input_conditioner #(
      .DB_CYCLES      (DB),
      .MISS_Q_MAX     (3)
`ifdef MISS_LOCKOUT_EN
     ,.LOCKOUT_CYCLES (LOCK)
`endif
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .btn_start    (btn_start),
      .btn_miss     (btn_miss),
      .tick_ack     (tick_ack),
      .fail         (fail),
      .start        (start),
      .miss         (miss),
      .miss_count   (miss_count),
      .miss_dropped (miss_dropped)
   );

   always #5 clock = ~clock;

   typedef enum {K_START, K_GLITCH, K_MISS, K_MISS_ACK, K_ACK, K_FAIL_ON, K_FAIL_OFF} kind_e;

   // chg = index of the first edge (edge 0 samples the new stimulus) after which start or miss moved; -1 = none
   typedef struct {
      kind_e kind;
      bit    exp_start;
      bit    exp_miss;
      int    exp_count;
      int    exp_drops;
      int    exp_chg;
   } vec_t;

   vec_t tbl[27];
   vec_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // Stimulus level required before edge e of a step.
   task automatic drive_for_edge(input kind_e k, input int e);
      btn_start = (k == K_START && e < 10) || (k == K_GLITCH && e < 3);
      btn_miss  = (k == K_MISS || k == K_MISS_ACK) && e < 10;
      tick_ack  = (k == K_ACK && e == 0) || (k == K_MISS_ACK && e == 7);
      if (k == K_FAIL_ON  && e == 0) fail = 1'b1;
      if (k == K_FAIL_OFF && e == 0) fail = 1'b0;
   endtask

   // Called 1ns after a rising edge; returns 1ns after the 20th edge of the step.
   task automatic run_step(input kind_e k, output int chg, output int drops);
      logic s0, m0;
      s0    = start;
      m0    = miss;
      chg   = -1;
      drops = 0;
      drive_for_edge(k, 0);
      for (int e = 0; e < 20; e++) begin
         @(posedge clock);
         #1;
         if (chg < 0 && (start !== s0 || miss !== m0)) chg = e;
         if (miss_dropped) drops++;
         drive_for_edge(k, e + 1);
      end
   endtask

   initial begin
      int   chg;
      int   drops;
      int   cnt_now;
      vec_t exp;

      //            kind        start miss count drops chg
      tbl[0]  = '{K_MISS,     1'b0, 1'b0, 0, 0, -1};  // not running: ignored
      tbl[1]  = '{K_START,    1'b1, 1'b0, 0, 0,  7};
      tbl[2]  = '{K_START,    1'b0, 1'b0, 0, 0,  7};
      tbl[3]  = '{K_GLITCH,   1'b0, 1'b0, 0, 0, -1};
      tbl[4]  = '{K_START,    1'b1, 1'b0, 0, 0,  7};
      tbl[5]  = '{K_MISS,     1'b1, 1'b1, 1, 0,  7};
      tbl[6]  = '{K_ACK,      1'b1, 1'b0, 1, 0,  0};
      tbl[7]  = '{K_MISS,     1'b1, 1'b1, 2, 0,  7};
      tbl[8]  = '{K_MISS,     1'b1, 1'b1, 3, 0, -1};
      tbl[9]  = '{K_MISS,     1'b1, 1'b1, 4, 0, -1};  // queue now full
      tbl[10] = '{K_MISS,     1'b1, 1'b1, 4, 1, -1};  // dropped
      tbl[11] = '{K_ACK,      1'b1, 1'b1, 4, 0, -1};
      tbl[12] = '{K_ACK,      1'b1, 1'b1, 4, 0, -1};
      tbl[13] = '{K_ACK,      1'b1, 1'b0, 4, 0,  0};
      tbl[14] = '{K_ACK,      1'b1, 1'b0, 4, 0, -1};  // ack on empty queue
      tbl[15] = '{K_MISS_ACK, 1'b1, 1'b1, 5, 0,  7};  // q 0 -> 1
      tbl[16] = '{K_MISS,     1'b1, 1'b1, 6, 0, -1};
      tbl[17] = '{K_MISS_ACK, 1'b1, 1'b1, 7, 0, -1};  // q stays 2
      tbl[18] = '{K_ACK,      1'b1, 1'b1, 7, 0, -1};
      tbl[19] = '{K_ACK,      1'b1, 1'b0, 7, 0,  0};
      tbl[20] = '{K_MISS,     1'b1, 1'b1, 8, 0,  7};
      tbl[21] = '{K_MISS,     1'b1, 1'b1, 9, 0, -1};
      tbl[22] = '{K_FAIL_ON,  1'b0, 1'b0, 9, 0,  0};
      tbl[23] = '{K_MISS,     1'b0, 1'b0, 9, 0, -1};
      tbl[24] = '{K_START,    1'b0, 1'b0, 9, 0, -1};
      tbl[25] = '{K_FAIL_OFF, 1'b0, 1'b0, 9, 0, -1};
      tbl[26] = '{K_START,    1'b1, 1'b0, 9, 0,  7};

      btn_start = 1'b0;
      btn_miss  = 1'b0;
      tick_ack  = 1'b0;
      fail      = 1'b0;
      reset     = 1'b1;
      #1;
      check("reset start", start, 0);
      check("reset miss", miss, 0);
      check("reset miss_count", miss_count, 0);
      check("reset miss_dropped", miss_dropped, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         run_step(tbl[i].kind, chg, drops);
         exp = exp_q.pop_front();
         check($sformatf("step%0d start", i), start, exp.exp_start);
         check($sformatf("step%0d miss", i), miss, exp.exp_miss);
         check($sformatf("step%0d miss_count", i), miss_count, exp.exp_count);
         check($sformatf("step%0d drops", i), drops, exp.exp_drops);
         check($sformatf("step%0d change_edge", i), chg, exp.exp_chg);
      end

      // Request is held across a long gap without ticks.
      run_step(K_MISS, chg, drops);
      repeat (30) @(posedge clock);
      #1;
      check("hold miss", miss, 1);
      check("hold count", miss_count, 10);
      run_step(K_ACK, chg, drops);
      check("hold ack release edge", chg, 0);
      check("hold ack miss", miss, 0);

      // Two debounced presses 8 cycles apart: lockout swallows the second one.
      drops = 0;
      for (int e = 0; e < 30; e++) begin
         btn_miss = (e < 4) || (e >= 8 && e < 12);
         @(posedge clock);
         #1;
         if (miss_dropped) drops++;
      end
      btn_miss = 1'b0;
`ifdef MISS_LOCKOUT_EN
      check("double press count", miss_count, 11);
`else
      check("double press count", miss_count, 12);
`endif
      check("double press drops", drops, 0);
      check("double press miss", miss, 1);
      run_step(K_ACK, chg, drops);
      run_step(K_ACK, chg, drops);
      check("double press drained", miss, 0);

      // Count saturates at 255, press+ack pairs keep the queue from filling.
      cnt_now = 0;
      for (int n = 0; n < 250; n++) begin
         run_step(K_MISS_ACK, chg, drops);
         cnt_now += drops;
      end
      check("saturate count", miss_count, 255);
      check("saturate drops", cnt_now, 0);
      check("saturate miss", miss, 1);
      check("saturate start", start, 1);

      // Asynchronous reset in the middle of a start debounce.
      btn_start = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async reset start", start, 0);
      check("async reset miss", miss, 0);
      check("async reset count", miss_count, 0);
      check("async reset dropped", miss_dropped, 0);
      btn_start = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check("post reset start", start, 0);
      check("post reset count", miss_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
